// File: rtl/paddle_key_if.sv
// Key pad / game core signal bundle for the paddle key controller.
// master drives the raw keys and vsync, slave is the controller.
interface paddle_key_if;
    logic [3:0] keys;
    logic       vsync;
    logic [7:0] hpaddle;
    logic       game_enable;
    logic       serve;
    logic [1:0] state;

    modport master (
        output keys, vsync,
        input  hpaddle, game_enable, serve, state
    );

    modport slave (
        input  keys, vsync,
        output hpaddle, game_enable, serve, state
    );
endinterface

// File: rtl/paddle_key_controller.sv
// Debounced 4-key pad to paddle position plus IDLE/SERVE/PLAY/PAUSE game sequencer.
// Paddle moves once per frame tick with a speed that ramps while a direction is held.

module key_debounce #(
    parameter int DB_W     = 16,
    parameter int DB_COUNT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);
    logic            s1, s2;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // counter only runs while the synced key disagrees with the filtered value
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_COUNT - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module paddle_key_controller #(
    parameter int DB_W        = 16,
    parameter int DB_COUNT    = 50000,
    parameter int PADDLE_MIN  = 0,
    parameter int PADDLE_MAX  = 224,
    parameter int PADDLE_HOME = 112,
    parameter int SPEED_MIN   = 1,
    parameter int SPEED_MAX   = 4,
    parameter int RAMP_FRAMES = 8
) (
    input logic         clk,
    input logic         reset,
    paddle_key_if.slave bus
);
    localparam int NUM_KEYS = 4;
    localparam int RAMP_W   = $clog2(RAMP_FRAMES + 1);
    localparam logic signed [9:0] MIN_S = 10'(PADDLE_MIN);
    localparam logic signed [9:0] MAX_S = 10'(PADDLE_MAX);

    typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, PLAY = 2'b10, PAUSE = 2'b11} state_t;
    typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_LEFT = 2'b01, DIR_RIGHT = 2'b10} dir_t;

    logic [NUM_KEYS-1:0] key_db, key_db_q;
    logic                start_edge, pause_edge;
    logic                vs_s1, vs_s2, vs_q, frame_tick;

    state_t              st;
    logic [7:0]          hpaddle_r;
    logic                game_enable_r, serve_r;
    logic [2:0]          speed;
    logic [RAMP_W-1:0]   ramp;
    dir_t                last_dir;

    dir_t                cur_dir;
    logic [2:0]          nxt_speed;
    logic [RAMP_W-1:0]   nxt_ramp;
    logic [7:0]          nxt_pos;
    logic signed [9:0]   pos_l, pos_r;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
        key_debounce #(.DB_W(DB_W), .DB_COUNT(DB_COUNT)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.keys[i]),
            .db    (key_db[i])
        );
    end

    assign start_edge = key_db[2] & ~key_db_q[2];
    assign pause_edge = key_db[3] & ~key_db_q[3];
    assign frame_tick = vs_s2 & ~vs_q;

    assign bus.hpaddle     = hpaddle_r;
    assign bus.game_enable = game_enable_r;
    assign bus.serve       = serve_r;
    assign bus.state       = st;

    // Next-tick motion: speed/ramp update first, the move then uses the updated speed.
    always_comb begin
        cur_dir = DIR_NONE;
        if (key_db[0] && !key_db[1])
            cur_dir = DIR_LEFT;
        else if (key_db[1] && !key_db[0])
            cur_dir = DIR_RIGHT;

        nxt_speed = 3'(SPEED_MIN);
        nxt_ramp  = '0;
        nxt_pos   = hpaddle_r;
        if (cur_dir != DIR_NONE && cur_dir == last_dir) begin
            if (ramp == RAMP_W'(RAMP_FRAMES - 1)) begin
                nxt_ramp  = '0;
                nxt_speed = (speed >= 3'(SPEED_MAX)) ? 3'(SPEED_MAX) : speed + 3'd1;
            end else begin
                nxt_ramp  = ramp + 1'b1;
                nxt_speed = speed;
            end
        end

        // 10-bit signed so the sum/difference can never wrap past 0 or 255
        pos_l = $signed({2'b00, hpaddle_r}) - $signed({7'b0, nxt_speed});
        pos_r = $signed({2'b00, hpaddle_r}) + $signed({7'b0, nxt_speed});
        if (cur_dir == DIR_LEFT)
            nxt_pos = (pos_l < MIN_S) ? 8'(PADDLE_MIN) : pos_l[7:0];
        else if (cur_dir == DIR_RIGHT)
            nxt_pos = (pos_r > MAX_S) ? 8'(PADDLE_MAX) : pos_r[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_db_q      <= '0;
            vs_s1         <= 1'b0;
            vs_s2         <= 1'b0;
            vs_q          <= 1'b0;
            st            <= IDLE;
            hpaddle_r     <= 8'(PADDLE_HOME);
            game_enable_r <= 1'b0;
            serve_r       <= 1'b0;
            speed         <= 3'(SPEED_MIN);
            ramp          <= '0;
            last_dir      <= DIR_NONE;
        end else begin
            key_db_q <= key_db;
            vs_s1    <= bus.vsync;
            vs_s2    <= vs_s1;
            vs_q     <= vs_s2;
            serve_r  <= 1'b0;
            case (st)
                IDLE: begin
                    hpaddle_r <= 8'(PADDLE_HOME);
                    speed     <= 3'(SPEED_MIN);
                    ramp      <= '0;
                    last_dir  <= DIR_NONE;
                    if (start_edge) begin
                        st      <= SERVE;
                        serve_r <= 1'b1;
                    end
                end
                SERVE: begin
                    st            <= PLAY;
                    game_enable_r <= 1'b1;
                end
                PLAY: begin
                    if (frame_tick) begin
                        hpaddle_r <= nxt_pos;
                        speed     <= nxt_speed;
                        ramp      <= nxt_ramp;
                        last_dir  <= cur_dir;
                    end
                    if (pause_edge) begin
                        st            <= PAUSE;
                        game_enable_r <= 1'b0;
                    end
                end
                PAUSE: begin
                    speed    <= 3'(SPEED_MIN);
                    ramp     <= '0;
                    last_dir <= DIR_NONE;
                    // pause wins over start when both arrive together
                    if (pause_edge) begin
                        st            <= PLAY;
                        game_enable_r <= 1'b1;
                    end else if (start_edge) begin
                        st        <= IDLE;
                        hpaddle_r <= 8'(PADDLE_HOME);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_paddle_key_controller.sv
// Bench for paddle_key_controller: directed game sequence plus random key holds
// checked against a per-frame arithmetic model of paddle position.
module tb_paddle_key_controller;
    localparam int DBC  = 4;
    localparam int PMIN = 0;
    localparam int PMAX = 224;
    localparam int HOME = 112;
    localparam int SMIN = 1;
    localparam int SMAX = 4;
    localparam int RAMP = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    paddle_key_if bus();

    paddle_key_controller #(
        .DB_W(16), .DB_COUNT(DBC), .PADDLE_MIN(PMIN), .PADDLE_MAX(PMAX),
        .PADDLE_HOME(HOME), .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .RAMP_FRAMES(RAMP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int m_pos, m_dir, m_run;
    bit m_play;
    int n_serve;
    bit serve_state_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Model: speed depends only on how many consecutive same-direction ticks preceded.
    task automatic model_tick();
        int dir, spd;
        if (!m_play) return;
        dir = (bus.keys[0] && !bus.keys[1]) ? -1 : (bus.keys[1] && !bus.keys[0]) ? 1 : 0;
        if (dir == 0) begin
            m_dir = 0;
            m_run = 0;
        end else begin
            if (dir == m_dir) m_run++;
            else m_run = 0;
            m_dir = dir;
            spd = SMIN + m_run / RAMP;
            if (spd > SMAX) spd = SMAX;
            m_pos = m_pos + dir * spd;
            if (m_pos < PMIN) m_pos = PMIN;
            if (m_pos > PMAX) m_pos = PMAX;
        end
    endtask

    task automatic press(input logic [3:0] mask, input int len);
        n_serve = 0;
        serve_state_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.keys = (i < len) ? (bus.keys | mask) : (bus.keys & ~mask);
            @(negedge clk);
            if (bus.serve === 1'b1) begin
                n_serve++;
                if (bus.state !== 2'b01) serve_state_ok = 1'b0;
            end
        end
    endtask

    task automatic set_keys(input logic [1:0] lr);
        bus.keys[1:0] = lr;
        repeat (20) @(negedge clk);
    endtask

    task automatic frames_chk(input string tag, input int n);
        for (int f = 0; f < n; f++) begin
            bus.vsync = 1'b1;
            repeat (50) @(negedge clk);
            model_tick();
            bus.vsync = 1'b0;
            repeat (50) @(negedge clk);
            chk(tag, 32'(bus.hpaddle), 32'(m_pos));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kind, nf;
        bus.keys  = 4'b0;
        bus.vsync = 1'b0;
        reset     = 1'b1;
        m_pos = HOME; m_dir = 0; m_run = 0; m_play = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hpaddle", 32'(bus.hpaddle), HOME);
        chk("rst_enable", 32'(bus.game_enable), 0);
        chk("rst_serve", 32'(bus.serve), 0);
        chk("rst_state", 32'(bus.state), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        press(4'b0100, 3);
        chk("glitch_serve", n_serve, 0);
        chk("glitch_state", 32'(bus.state), 0);

        press(4'b0100, 10);
        chk("start_serve_cnt", n_serve, 1);
        chk("start_serve_in_serve", 32'(serve_state_ok), 1);
        chk("start_state", 32'(bus.state), 2);
        chk("start_enable", 32'(bus.game_enable), 1);
        m_play = 1'b1;

        set_keys(2'b10);
        frames_chk("right_ramp", 20);
        chk("right20", 32'(bus.hpaddle), 148);

        set_keys(2'b01);
        frames_chk("left_edge", 60);
        chk("left_clamp", 32'(bus.hpaddle), 0);

        set_keys(2'b10);
        frames_chk("right_edge", 80);
        chk("right_clamp", 32'(bus.hpaddle), 224);

        set_keys(2'b11);
        frames_chk("both_keys", 5);
        chk("both_hold", 32'(bus.hpaddle), 224);
        set_keys(2'b01);
        frames_chk("after_both", 1);
        chk("speed_reset", 32'(bus.hpaddle), 223);
        set_keys(2'b00);

        press(4'b1000, 10);
        m_play = 1'b0; m_dir = 0;
        chk("pause_state", 32'(bus.state), 3);
        chk("pause_enable", 32'(bus.game_enable), 0);
        set_keys(2'b01);
        frames_chk("paused_move", 3);
        chk("frozen", 32'(bus.hpaddle), 223);
        set_keys(2'b00);
        press(4'b1000, 10);
        m_play = 1'b1;
        chk("resume_state", 32'(bus.state), 2);
        chk("resume_enable", 32'(bus.game_enable), 1);

        press(4'b1000, 10);
        press(4'b1100, 10);
        chk("both_edges_state", 32'(bus.state), 2);

        press(4'b1000, 10);
        m_play = 1'b0; m_dir = 0;
        press(4'b0100, 10);
        chk("abandon_state", 32'(bus.state), 0);
        chk("abandon_home", 32'(bus.hpaddle), HOME);
        chk("abandon_no_serve", n_serve, 0);
        m_pos = HOME;

        press(4'b0100, 10);
        chk("restart_state", 32'(bus.state), 2);
        m_play = 1'b1; m_dir = 0; m_run = 0;

        for (int s = 0; s < 14; s++) begin
            kind = $urandom_range(0, 4);
            if (kind == 4) begin
                press(4'b1000, 10);
                m_play = 1'b0; m_dir = 0;
                set_keys(2'($urandom_range(0, 3)));
                nf = $urandom_range(1, 3);
                frames_chk("rand_paused", nf);
                press(4'b1000, 10);
                m_play = 1'b1;
                chk("rand_resume", 32'(bus.state), 2);
            end else begin
                set_keys(2'(kind));
                nf = $urandom_range(1, 10);
                frames_chk("rand_move", nf);
            end
        end

        set_keys(2'b10);
        bus.vsync = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_hpaddle", 32'(bus.hpaddle), HOME);
        chk("midrst_enable", 32'(bus.game_enable), 0);
        chk("midrst_serve", 32'(bus.serve), 0);
        chk("midrst_state", 32'(bus.state), 0);
        @(negedge clk);
        reset = 1'b0;
        bus.vsync = 1'b0;
        bus.keys = 4'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
